// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with stall, flush and optional load-use hazard (ID_EX_HAZARD_EN)
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic              id_RegDst_i,
    input  logic [1:0]        id_ALUOp_i,
    input  logic              id_ALUSrc_i,
    input  logic              id_RegWrite_i,
    input  logic              id_MemWrite_i,
    input  logic              id_MemRead_i,
    input  logic              id_MemtoReg_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    output logic              ex_RegDst_o,
    output logic [1:0]        ex_ALUOp_o,
    output logic              ex_ALUSrc_o,
    output logic              ex_RegWrite_o,
    output logic              ex_MemWrite_o,
    output logic              ex_MemRead_o,
    output logic              ex_MemtoReg_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              valid_o,
    output logic              hazard_o
);

    logic              r_valid;
    logic              r_RegDst;
    logic [1:0]        r_ALUOp;
    logic              r_ALUSrc;
    logic              r_RegWrite;
    logic              r_MemWrite;
    logic              r_MemRead;
    logic              r_MemtoReg;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;

    logic w_hazard;
    logic w_bubble;
    logic w_data_en;

`ifdef ID_EX_HAZARD_EN
    // A load in EX whose destination is read by the instruction in ID.
    assign w_hazard = r_valid & r_MemRead & (r_rt != '0)
                      & ((r_rt == id_rs_i) | (r_rt == id_rt_i));
`else
    assign w_hazard = 1'b0;
`endif

    assign w_bubble  = flush_i | w_hazard;
    assign w_data_en = w_bubble | ~stall_i;

    // Control fields are qualified by id_valid_i so a BUBBLE never writes state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_RegDst   <= 1'b0;
            r_ALUOp    <= '0;
            r_ALUSrc   <= 1'b0;
            r_RegWrite <= 1'b0;
            r_MemWrite <= 1'b0;
            r_MemRead  <= 1'b0;
            r_MemtoReg <= 1'b0;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_RegDst   <= 1'b0;
            r_ALUOp    <= '0;
            r_ALUSrc   <= 1'b0;
            r_RegWrite <= 1'b0;
            r_MemWrite <= 1'b0;
            r_MemRead  <= 1'b0;
            r_MemtoReg <= 1'b0;
        end else if (!stall_i) begin
            r_valid    <= id_valid_i;
            r_RegDst   <= id_RegDst_i & id_valid_i;
            r_ALUOp    <= id_ALUOp_i & {2{id_valid_i}};
            r_ALUSrc   <= id_ALUSrc_i & id_valid_i;
            r_RegWrite <= id_RegWrite_i & id_valid_i;
            r_MemWrite <= id_MemWrite_i & id_valid_i;
            r_MemRead  <= id_MemRead_i & id_valid_i;
            r_MemtoReg <= id_MemtoReg_i & id_valid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
        end else if (w_data_en) begin
            r_rs_data <= id_rs_data_i;
            r_rt_data <= id_rt_data_i;
            r_imm     <= id_imm_i;
            r_rs      <= id_rs_i;
            r_rt      <= id_rt_i;
            r_rd      <= id_rd_i;
        end
    end

    assign valid_o       = r_valid;
    assign hazard_o      = w_hazard;
    assign ex_RegDst_o   = r_RegDst;
    assign ex_ALUOp_o    = r_ALUOp;
    assign ex_ALUSrc_o   = r_ALUSrc;
    assign ex_RegWrite_o = r_RegWrite;
    assign ex_MemWrite_o = r_MemWrite;
    assign ex_MemRead_o  = r_MemRead;
    assign ex_MemtoReg_o = r_MemtoReg;
    assign ex_rs_data_o  = r_rs_data;
    assign ex_rt_data_o  = r_rt_data;
    assign ex_imm_o      = r_imm;
    assign ex_rs_o       = r_rs;
    assign ex_rt_o       = r_rt;
    assign ex_rd_o       = r_rd;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed self-checking bench for id_ex_pipe
module tb_id_ex_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, id_valid_i;
    logic        id_RegDst_i, id_ALUSrc_i, id_RegWrite_i, id_MemWrite_i, id_MemRead_i, id_MemtoReg_i;
    logic [1:0]  id_ALUOp_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic        ex_RegDst_o, ex_ALUSrc_o, ex_RegWrite_o, ex_MemWrite_o, ex_MemRead_o, ex_MemtoReg_o;
    logic [1:0]  ex_ALUOp_o;
    logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
    logic        valid_o, hazard_o;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [7:0] LW_CTRL = 8'h1B;
    localparam logic [7:0] R_CTRL  = 8'hC8;

    logic [7:0] ex_ctrl;
    assign ex_ctrl = {ex_RegDst_o, ex_ALUOp_o, ex_ALUSrc_o, ex_RegWrite_o,
                      ex_MemWrite_o, ex_MemRead_o, ex_MemtoReg_o};

    always #5 clk_i = ~clk_i;

    id_ex_pipe #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_RegDst_i(id_RegDst_i), .id_ALUOp_i(id_ALUOp_i),
        .id_ALUSrc_i(id_ALUSrc_i), .id_RegWrite_i(id_RegWrite_i), .id_MemWrite_i(id_MemWrite_i),
        .id_MemRead_i(id_MemRead_i), .id_MemtoReg_i(id_MemtoReg_i),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .ex_RegDst_o(ex_RegDst_o), .ex_ALUOp_o(ex_ALUOp_o), .ex_ALUSrc_o(ex_ALUSrc_o),
        .ex_RegWrite_o(ex_RegWrite_o), .ex_MemWrite_o(ex_MemWrite_o), .ex_MemRead_o(ex_MemRead_o),
        .ex_MemtoReg_o(ex_MemtoReg_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
        .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
        .valid_o(valid_o), .hazard_o(hazard_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ctrl = {RegDst, ALUOp[1:0], ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg}
    task automatic set_id(input logic v, input logic [7:0] ctrl, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid_i = v;
        {id_RegDst_i, id_ALUOp_i, id_ALUSrc_i, id_RegWrite_i,
         id_MemWrite_i, id_MemRead_i, id_MemtoReg_i} = ctrl;
        id_rs_data_i = rsd;
        id_rt_data_i = rtd;
        id_imm_i     = imm;
        id_rs_i      = rs;
        id_rt_i      = rt;
        id_rd_i      = rd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"},  {56'd0, ex_ctrl}, 64'd0);
        check({tag, "_valid"}, {63'd0, valid_o}, 64'd0);
        check({tag, "_data"},  {ex_rs_data_o, ex_imm_o}, 64'd0);
        check({tag, "_idx"},   {49'd0, ex_rs_o, ex_rt_o, ex_rd_o}, 64'd0);
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        set_id(1'b0, 8'h00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk_i);
        check_all_zero("reset");
        check("reset_hazard", {63'd0, hazard_o}, 64'd0);

        // 1: lw loads in one edge
        rst_i = 1'b0;
        set_id(1'b1, LW_CTRL, 32'h12345678, 32'hCAFEBABE, 32'h00000004, 5'd9, 5'd8, 5'd0);
        @(negedge clk_i);
        check("lw_ctrl",  {56'd0, ex_ctrl}, {56'd0, LW_CTRL});
        check("lw_valid", {63'd0, valid_o}, 64'd1);
        check("lw_rsd",   {32'd0, ex_rs_data_o}, 64'h12345678);
        check("lw_rtd",   {32'd0, ex_rt_data_o}, 64'hCAFEBABE);
        check("lw_idx",   {49'd0, ex_rs_o, ex_rt_o, ex_rd_o}, {49'd0, 5'd9, 5'd8, 5'd0});

        // 2: stall for 3 edges while ID changes to R-type
        stall_i = 1'b1;
        set_id(1'b1, R_CTRL, 32'h11111111, 32'h22222222, 32'hFFFF8020, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_ctrl", {56'd0, ex_ctrl}, {56'd0, LW_CTRL});
            check("stall_rsd",  {32'd0, ex_rs_data_o}, 64'h12345678);
            check("stall_rt",   {59'd0, ex_rt_o}, 64'd8);
        end
        stall_i = 1'b0;
        @(negedge clk_i);
        check("rtype_ctrl", {56'd0, ex_ctrl}, {56'd0, R_CTRL});
        check("rtype_imm",  {32'd0, ex_imm_o}, 64'hFFFF8020);
        check("rtype_idx",  {49'd0, ex_rs_o, ex_rt_o, ex_rd_o}, {49'd0, 5'd1, 5'd2, 5'd3});

        // 3: flush and stall together -> bubble
        flush_i = 1'b1; stall_i = 1'b1;
        @(negedge clk_i);
        check("flush_valid", {63'd0, valid_o}, 64'd0);
        check("flush_ctrl",  {56'd0, ex_ctrl}, 64'd0);
        flush_i = 1'b0; stall_i = 1'b0;

        // id_valid_i=0 must zero control even on a plain load
        set_id(1'b0, R_CTRL, 32'h33333333, 32'h44444444, 32'h0, 5'd4, 5'd5, 5'd6);
        @(negedge clk_i);
        check("novalid_valid", {63'd0, valid_o}, 64'd0);
        check("novalid_ctrl",  {56'd0, ex_ctrl}, 64'd0);

        // 4: async reset between edges
        set_id(1'b1, R_CTRL, 32'h11111111, 32'h22222222, 32'hFFFF8020, 5'd1, 5'd2, 5'd3);
        @(negedge clk_i);
        check("pre_rst_valid", {63'd0, valid_o}, 64'd1);
        #2 rst_i = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk_i);
        check_all_zero("held_rst");
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_valid", {63'd0, valid_o}, 64'd1);
        check("post_rst_ctrl",  {56'd0, ex_ctrl}, {56'd0, R_CTRL});

        // 5: load-use pair
        set_id(1'b1, LW_CTRL, 32'h12345678, 32'h0, 32'h4, 5'd9, 5'd8, 5'd0);
        @(negedge clk_i);
        check("lu_lw_memread", {63'd0, ex_MemRead_o}, 64'd1);
        set_id(1'b1, R_CTRL, 32'h55555555, 32'h66666666, 32'h20, 5'd8, 5'd3, 5'd7);
        #1;
`ifdef ID_EX_HAZARD_EN
        check("lu_hazard", {63'd0, hazard_o}, 64'd1);
        @(negedge clk_i);
        check("lu_bubble_valid",  {63'd0, valid_o}, 64'd0);
        check("lu_bubble_ctrl",   {56'd0, ex_ctrl}, 64'd0);
        check("lu_bubble_hazard", {63'd0, hazard_o}, 64'd0);
        @(negedge clk_i);
`else
        check("lu_hazard", {63'd0, hazard_o}, 64'd0);
        @(negedge clk_i);
`endif
        check("lu_load_valid", {63'd0, valid_o}, 64'd1);
        check("lu_load_ctrl",  {56'd0, ex_ctrl}, {56'd0, R_CTRL});
        check("lu_load_rs",    {59'd0, ex_rs_o}, 64'd8);

        // 6: lw to $zero never raises a hazard
        set_id(1'b1, LW_CTRL, 32'h0, 32'h0, 32'h8, 5'd9, 5'd0, 5'd0);
        @(negedge clk_i);
        set_id(1'b1, R_CTRL, 32'h77777777, 32'h0, 32'h20, 5'd0, 5'd0, 5'd10);
        #1 check("zero_hazard", {63'd0, hazard_o}, 64'd0);
        @(negedge clk_i);
        check("zero_load_valid", {63'd0, valid_o}, 64'd1);
        check("zero_load_rd",    {59'd0, ex_rd_o}, 64'd10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
